// File: rtl/prog_loader.sv
// ============================================================================
// prog_loader : byte-stream program loader for the 1024-word instruction memory
// Revision    : 1.0
// ============================================================================
`default_nettype none

module prog_loader #(
    parameter int          ADDR_W  = 10,
    parameter int          DEPTH   = 1024,
    parameter logic [5:0]  HALT_OP = 6'b111111
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_load,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              err_overflow,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_RUN   = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam logic [ADDR_W:0]   c_depth    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_cnt_one  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t          r_state;
    logic [1:0]      r_byte_idx;
    logic [23:0]     r_asm;
    logic [ADDR_W:0] w_count_next;

    assign byte_ready   = (r_state == S_RECV);
    assign w_count_next = word_count + c_cnt_one;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_byte_idx   <= 2'd0;
            r_asm        <= 24'd0;
            im_we        <= 1'b0;
            im_addr      <= '0;
            im_wdata     <= 32'd0;
            core_rst     <= 1'b1;
            done         <= 1'b0;
            err_overflow <= 1'b0;
            word_count   <= '0;
        end else begin
            // im_we is only ever high for the single WRITE cycle
            im_we <= 1'b0;
            if (start_load) begin
                r_state      <= S_RECV;
                r_byte_idx   <= 2'd0;
                im_addr      <= '0;
                word_count   <= '0;
                core_rst     <= 1'b1;
                done         <= 1'b0;
                err_overflow <= 1'b0;
            end else begin
                case (r_state)
                    S_RECV: begin
                        if (byte_valid) begin
                            if (r_byte_idx == 2'd3) begin
                                im_wdata   <= {r_asm, byte_data};
                                im_we      <= 1'b1;
                                r_byte_idx <= 2'd0;
                                r_state    <= S_WRITE;
                            end else begin
                                r_asm      <= {r_asm[15:0], byte_data};
                                r_byte_idx <= r_byte_idx + 2'd1;
                            end
                        end
                    end
                    S_WRITE: begin
                        word_count <= w_count_next;
                        // Overflow is tested before the address moves, so im_addr never wraps
                        if (im_wdata[31:26] == HALT_OP) begin
                            r_state  <= S_RUN;
                            core_rst <= 1'b0;
                            done     <= 1'b1;
                        end else if (w_count_next == c_depth) begin
                            r_state      <= S_ERR;
                            err_overflow <= 1'b1;
                        end else begin
                            r_state <= S_RECV;
                            im_addr <= im_addr + c_addr_one;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
// tb_prog_loader : self-checking bench for prog_loader (vectors, sequences, random loads)
// Revision       : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_prog_loader;

    logic        clk;
    logic        rst;
    logic        start_load;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        im_we;
    logic [9:0]  im_addr;
    logic [31:0] im_wdata;
    logic        core_rst;
    logic        done;
    logic        err_overflow;
    logic [10:0] word_count;

    prog_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start_load   (start_load),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .im_we        (im_we),
        .im_addr      (im_addr),
        .im_wdata     (im_wdata),
        .core_rst     (core_rst),
        .done         (done),
        .err_overflow (err_overflow),
        .word_count   (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    // Transaction-level reference: bytes in, words out, plus load status flags
    logic [7:0] m_bytes[$];
    int         m_words;
    bit         m_halted;
    bit         m_overflow;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_bytes.delete();
        m_words    = 0;
        m_halted   = 1'b0;
        m_overflow = 1'b0;
    endtask

    task automatic model_accept(input logic [7:0] b);
        logic [31:0] w;
        wr_t         e;
        m_bytes.push_back(b);
        if (m_bytes.size() == 4) begin
            w = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
            m_bytes.delete();
            e.addr = 10'(m_words);
            e.data = w;
            exp_q.push_back(e);
            m_words++;
            if (w[31:26] == 6'h3F)  m_halted = 1'b1;
            else if (m_words == 1024) m_overflow = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected", im_addr, im_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (im_addr !== e.addr || im_wdata !== e.data) begin
                    errors++;
                    $display("FAIL write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                             im_addr, im_wdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic idle(input int n);
        byte_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output int stalls);
        logic rdy;
        byte_valid = 1'b1;
        byte_data  = b;
        stalls     = 0;
        forever begin
            rdy = byte_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                model_accept(b);
                break;
            end
            stalls++;
            if (stalls > 50) begin
                chk("byte_accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        int st;
        for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], st);
    endtask

    task automatic pulse_start();
        start_load = 1'b1;
        @(posedge clk);
        #1;
        start_load = 1'b0;
        byte_valid = 1'b0;
        model_clear();
    endtask

    task automatic check_status();
        int ea;
        ea = (m_halted || m_overflow) ? m_words - 1 : m_words;
        chk("word_count", 32'(word_count), 32'(m_words));
        chk("core_rst", 32'(core_rst), 32'(!m_halted));
        chk("done", 32'(done), 32'(m_halted));
        chk("err_overflow", 32'(err_overflow), 32'(m_overflow));
        chk("im_addr", 32'(im_addr), 32'(ea));
        chk("pending_writes", 32'(exp_q.size()), 32'd0);
    endtask

    typedef struct {
        bit          restart;
        logic [31:0] word;
        bit          exp_core_rst;
        bit          exp_done;
        int          exp_wc;
    } vec_t;
    vec_t vecs[6];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          st;
        int          n;
        logic [31:0] w;

        vecs[0] = '{1'b1, 32'h2022_0005, 1'b1, 1'b0, 1};
        vecs[1] = '{1'b0, 32'hFC00_0000, 1'b0, 1'b1, 2};
        vecs[2] = '{1'b1, 32'h1234_5678, 1'b1, 1'b0, 1};
        vecs[3] = '{1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 2};
        vecs[4] = '{1'b1, 32'hF800_0000, 1'b1, 1'b0, 1};
        vecs[5] = '{1'b0, 32'hFC00_00FF, 1'b0, 1'b1, 2};

        rst = 1'b0; start_load = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        model_clear();
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("rst_im_we", 32'(im_we), 32'd0);
        chk("rst_im_addr", 32'(im_addr), 32'd0);
        chk("rst_im_wdata", im_wdata, 32'd0);
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err_overflow", 32'(err_overflow), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        rst = 1'b0;

        // Bytes offered in IDLE must be ignored
        byte_valid = 1'b1; byte_data = 8'hFC;
        repeat (3) begin @(posedge clk); #1; end
        chk("idle_byte_ready", 32'(byte_ready), 32'd0);
        idle(1);
        check_status();

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].restart) pulse_start();
            send_word(vecs[i].word);
            chk("write_byte_ready", 32'(byte_ready), 32'd0);
            chk("write_im_we", 32'(im_we), 32'd1);
            chk("write_core_rst_pre", 32'(core_rst), 32'd1);
            byte_valid = 1'b0;
            @(posedge clk);
            #1;
            chk("vec_core_rst", 32'(core_rst), 32'(vecs[i].exp_core_rst));
            chk("vec_done", 32'(done), 32'(vecs[i].exp_done));
            chk("vec_word_count", 32'(word_count), 32'(vecs[i].exp_wc));
        end
        idle(2);
        check_status();

        // Restart out of RUN
        pulse_start();
        chk("run_restart_core_rst", 32'(core_rst), 32'd1);
        chk("run_restart_done", 32'(done), 32'd0);
        chk("run_restart_ready", 32'(byte_ready), 32'd1);
        send_word(32'h0102_0304);
        idle(2);
        check_status();

        // Throughput with byte_valid held high: one stall after each 4th byte
        pulse_start();
        for (int wi = 0; wi < 3; wi++) begin
            for (int k = 0; k < 4; k++) begin
                send_byte(8'(16 * wi + k), st);
                chk("stall", 32'(st), (wi > 0 && k == 0) ? 32'd1 : 32'd0);
            end
        end
        idle(2);
        check_status();

        // Restart mid-word; byte presented with start_load is dropped
        pulse_start();
        send_byte(8'h55, st);
        send_byte(8'h66, st);
        byte_data = 8'h77;
        pulse_start();
        send_word(32'hAABB_CCDD);
        idle(2);
        chk("midword_wdata", im_wdata, 32'hAABB_CCDD);
        check_status();

        // Asynchronous reset between 3rd and 4th byte
        pulse_start();
        send_byte(8'h11, st);
        send_byte(8'h22, st);
        send_byte(8'h33, st);
        byte_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_core_rst", 32'(core_rst), 32'd1);
        chk("arst_byte_ready", 32'(byte_ready), 32'd0);
        chk("arst_im_wdata", im_wdata, 32'd0);
        chk("arst_word_count", 32'(word_count), 32'd0);
        chk("arst_im_we", 32'(im_we), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        idle(3);
        chk("post_rst_ready", 32'(byte_ready), 32'd0);
        check_status();

        // Overflow: DEPTH words with no halt
        pulse_start();
        for (int i = 0; i < 1024; i++) begin
            w = $urandom;
            if (w[31:26] == 6'h3F) w[26] = 1'b0;
            send_word(w);
        end
        byte_data = 8'hFC;
        repeat (6) begin @(posedge clk); #1; end
        chk("ovf_byte_ready", 32'(byte_ready), 32'd0);
        idle(1);
        check_status();
        pulse_start();
        chk("ovf_cleared", 32'(err_overflow), 32'd0);

        // Randomized loads with gaps, aborted words and optional halt
        for (int l = 0; l < 6; l++) begin
            pulse_start();
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 9) == 0) begin
                    repeat ($urandom_range(1, 3)) send_byte(8'($urandom), st);
                    pulse_start();
                    continue;
                end
                w = $urandom;
                if (i == n - 1 && (l % 3) != 2) w[31:26] = 6'h3F;
                else if (w[31:26] == 6'h3F) w[26] = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                    send_byte(w[31-8*k -: 8], st);
                end
            end
            idle(2);
            check_status();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
